button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer_pkg.sv | 19 +
 rtl/button_debouncer_if.sv | 13 +
 rtl/button_debouncer_channel.sv | 82 ++++++++
 rtl/button_debouncer.sv | 31 +++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the Basys3 button debouncer: FSM state encoding
// and default timing constants.
package basys3_io_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } deb_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;  // 10 ms at 100 MHz
    localparam int SYNC_STAGES_DEFAULT     = 2;

    function automatic logic state_is_high(input deb_state_t s);
        return (s == STABLE_HI) || (s == WAIT_LO);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Bundle of the raw button inputs and the debounced level/pulse outputs.
interface button_debouncer_if #(
    parameter int N_INPUTS = 5
);
    logic [N_INPUTS-1:0] btn_raw;
    logic [N_INPUTS-1:0] btn_level;
    logic [N_INPUTS-1:0] btn_press;
    logic [N_INPUTS-1:0] btn_release;

    // master drives the buttons, slave is the debouncer
    modport master (output btn_raw, input  btn_level, btn_press, btn_release);
    modport slave  (input  btn_raw, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/button_debouncer_channel.sv
// One debounce channel: synchronizer chain, 4-state stability FSM with
// counter, and registered press/release pulses.
module debounce_channel
    import basys3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // Last value before the increment that reaches DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   press_d, release_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '0;
            state_q       <= STABLE_LO;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // NOTE: defaults first so every path assigns every output and no
    // latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            STABLE_LO: if (sync) state_d = WAIT_HI;
            WAIT_HI: begin
                if (!sync) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: if (!sync) state_d = WAIT_LO;
            WAIT_LO: begin
                if (sync) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_LO;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = STABLE_LO;
        endcase
    end

    assign level = state_is_high(state_q);

endmodule

// File: rtl/button_debouncer.sv
// N-channel button debouncer: one independent debounce_channel per input.
module button_debouncer
    import basys3_io_pkg::*;
#(
    parameter int N_INPUTS        = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] btn_raw,
    output logic [N_INPUTS-1:0] btn_level,
    output logic [N_INPUTS-1:0] btn_press,
    output logic [N_INPUTS-1:0] btn_release
);

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

endmodule
